// File: rtl/batrider_textram_pkg.sv
// Shared encodings for the Batrider extra-text RAM block.
// Region codes, CPU FSM states and the CPU request bundle.
package batrider_textram_pkg;

  localparam logic [1:0] REG_VRAM   = 2'd0;
  localparam logic [1:0] REG_SEL    = 2'd1;
  localparam logic [1:0] REG_SCROLL = 2'd2;
  localparam logic [1:0] REG_NONE   = 2'd3;

  localparam int CLEAR_LEN = 4096;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ISSUE,
    ST_DATA,
    ST_ACK,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [11:0] addr;
    logic [15:0] din;
    logic [1:0]  dsn;
  } cpu_req_t;

  function automatic logic [1:0] dsn_to_be(input logic [1:0] dsn);
    return ~dsn;
  endfunction

endpackage

// File: rtl/batrider_textram_dp16.sv
// 16-bit dual-port RAM: port A byte-write plus registered read,
// port B read-only with registered address and data (2-cycle latency).
module batrider_textram_dp16 #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic [1:0]    a_be_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [15:0]   a_din_i,
  output logic [15:0]   a_dout_o,
  input  logic [AW-1:0] b_addr_i,
  output logic [15:0]   b_dout_o
);

  logic [15:0]   mem_q [2**AW];
  logic [15:0]   a_dout_q;
  logic [AW-1:0] b_addr_q;
  logic [15:0]   b_dout_q;

  // Reads see the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (a_be_i[0]) mem_q[a_addr_i][7:0]  <= a_din_i[7:0];
    if (a_be_i[1]) mem_q[a_addr_i][15:8] <= a_din_i[15:8];
    a_dout_q <= mem_q[a_addr_i];
    b_addr_q <= b_addr_i;
    b_dout_q <= mem_q[b_addr_q];
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/batrider_textram.sv
// Batrider extra-text storage: VRAM, line-select and line-scroll RAMs
// with CPU handshake port, renderer read ports and post-reset zero-fill.
module batrider_textram
  import batrider_textram_pkg::*;
#(
  parameter int VRAM_AW = 12,
  parameter int LRAM_AW = 8
) (
  input  logic               CLK96,
  input  logic               RESET96,
  input  logic               CPU_CS,
  input  logic               CPU_WE,
  input  logic [1:0]         CPU_SEL,
  input  logic [11:0]        CPU_ADDR,
  input  logic [15:0]        CPU_DIN,
  input  logic [1:0]         CPU_DSn,
  output logic [15:0]        CPU_DOUT,
  output logic               CPU_ACK,
  output logic               READY,
  input  logic [VRAM_AW-1:0] TEXTVRAM_ADDR,
  output logic [15:0]        TEXTVRAM_DATA,
  input  logic [LRAM_AW-1:0] TEXTSELECT_ADDR,
  output logic [15:0]        TEXTSELECT_DATA,
  input  logic [LRAM_AW-1:0] TEXTSCROLL_ADDR,
  output logic [15:0]        TEXTSCROLL_DATA
);

  localparam logic [VRAM_AW-1:0] CNT_LAST = VRAM_AW'(CLEAR_LEN - 1);

  state_t             state_q, state_d;
  logic [VRAM_AW-1:0] cnt_q;
  logic               cs_q;
  cpu_req_t           req_q;
  logic [15:0]        dout_q;
  logic               ready_q;

  logic cs_rise;
  logic clr_last;
  logic lram_clr;

  logic               clearing;
  logic               issue_wr;
  logic               ack;
  logic [1:0]         vram_be;
  logic [1:0]         sel_be;
  logic [1:0]         scr_be;
  logic [VRAM_AW-1:0] vram_addr;
  logic [LRAM_AW-1:0] lram_addr;
  logic [15:0]        wr_data;

  logic [15:0] vram_a, sel_a, scr_a;
  logic [15:0] vram_b, sel_b, scr_b;
  logic [15:0] rd_mux;

  assign cs_rise  = CPU_CS & ~cs_q;
  assign clr_last = (cnt_q == CNT_LAST);
  assign lram_clr = (cnt_q[VRAM_AW-1:LRAM_AW] == '0);

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) state_q <= ST_CLEAR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      ST_IDLE:  if (cs_rise) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_DATA;
      ST_DATA:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_HOLD;
      ST_HOLD:  if (!CPU_CS) state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    clearing  = (state_q == ST_CLEAR);
    issue_wr  = (state_q == ST_ISSUE) && req_q.we;
    ack       = (state_q == ST_ACK);
    vram_be   = 2'b00;
    sel_be    = 2'b00;
    scr_be    = 2'b00;
    vram_addr = req_q.addr[VRAM_AW-1:0];
    lram_addr = req_q.addr[LRAM_AW-1:0];
    wr_data   = req_q.din;
    if (clearing) begin
      vram_addr = cnt_q;
      lram_addr = cnt_q[LRAM_AW-1:0];
      wr_data   = 16'h0000;
      vram_be   = 2'b11;
      sel_be    = lram_clr ? 2'b11 : 2'b00;
      scr_be    = lram_clr ? 2'b11 : 2'b00;
    end else if (issue_wr) begin
      unique case (1'b1)
        req_q.sel == REG_VRAM:   vram_be = dsn_to_be(req_q.dsn);
        req_q.sel == REG_SEL:    sel_be  = dsn_to_be(req_q.dsn);
        req_q.sel == REG_SCROLL: scr_be  = dsn_to_be(req_q.dsn);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    unique case (1'b1)
      req_q.sel == REG_VRAM:   rd_mux = vram_a;
      req_q.sel == REG_SEL:    rd_mux = sel_a;
      req_q.sel == REG_SCROLL: rd_mux = scr_a;
      default:                 rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      req_q   <= '0;
      dout_q  <= 16'h0000;
      ready_q <= 1'b0;
    end else begin
      cs_q <= CPU_CS;
      if (clearing && !clr_last) cnt_q <= cnt_q + 1'b1;
      if (clearing && clr_last) ready_q <= 1'b1;
      if (state_q == ST_IDLE && cs_rise) begin
        req_q.we   <= CPU_WE;
        req_q.sel  <= CPU_SEL;
        req_q.addr <= CPU_ADDR;
        req_q.din  <= CPU_DIN;
        req_q.dsn  <= CPU_DSn;
      end
      if (state_q == ST_DATA && !req_q.we) dout_q <= rd_mux;
    end
  end

  batrider_textram_dp16 #(.AW(VRAM_AW)) u_vram (
    .clk_i    (CLK96),
    .a_be_i   (vram_be),
    .a_addr_i (vram_addr),
    .a_din_i  (wr_data),
    .a_dout_o (vram_a),
    .b_addr_i (TEXTVRAM_ADDR),
    .b_dout_o (vram_b)
  );

  batrider_textram_dp16 #(.AW(LRAM_AW)) u_sel (
    .clk_i    (CLK96),
    .a_be_i   (sel_be),
    .a_addr_i (lram_addr),
    .a_din_i  (wr_data),
    .a_dout_o (sel_a),
    .b_addr_i (TEXTSELECT_ADDR),
    .b_dout_o (sel_b)
  );

  batrider_textram_dp16 #(.AW(LRAM_AW)) u_scr (
    .clk_i    (CLK96),
    .a_be_i   (scr_be),
    .a_addr_i (lram_addr),
    .a_din_i  (wr_data),
    .a_dout_o (scr_a),
    .b_addr_i (TEXTSCROLL_ADDR),
    .b_dout_o (scr_b)
  );

  assign CPU_ACK         = ack;
  assign CPU_DOUT        = dout_q;
  assign READY           = ready_q;
  assign TEXTVRAM_DATA   = ready_q ? vram_b : 16'h0000;
  assign TEXTSELECT_DATA = ready_q ? sel_b  : 16'h0000;
  assign TEXTSCROLL_DATA = ready_q ? scr_b  : 16'h0000;

endmodule
